// File: rtl/encoder_scan_if.sv
// Request/index handshake bundle for encoder_scan.
// master drives requests and consumes indices; slave is the encoder.
interface encoder_scan_if;
  logic [7:0] in_vec;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [3:0] out_cnt;
  logic       zero;

  modport master (
    output in_vec,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_idx,
    input  out_valid,
    input  out_last,
    input  out_cnt,
    input  zero
  );

  modport slave (
    input  in_vec,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_idx,
    output out_valid,
    output out_last,
    output out_cnt,
    output zero
  );
endinterface

// File: rtl/encoder_scan.sv
// Sequential 8-to-3 encoder: accepts a request vector, then emits the index of every
// set bit, highest first, one per output handshake.
module encoder_scan #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  encoder_scan_if.slave  bus
);

  localparam int unsigned CntW = IDXW + 1;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pending_q, pending_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              zero_q, zero_d;

  logic [IDXW-1:0]   hi_idx;
  logic [CntW-1:0]   in_popcnt;
  logic              one_hot;
  logic              in_fire;
  logic              out_fire;

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_q[i]) hi_idx = IDXW'(i);
    end
  end

  always_comb begin
    in_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_popcnt = in_popcnt + CntW'(bus.in_vec[i]);
    end
  end

  assign one_hot = (pending_q != '0) && ((pending_q & (pending_q - 1'b1)) == '0);

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StScan);
  assign bus.out_idx   = (state_q == StScan) ? hi_idx : '0;
  assign bus.out_last  = (state_q == StScan) && one_hot;
  assign bus.out_cnt   = cnt_q;
  assign bus.zero      = zero_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    zero_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          pending_d = bus.in_vec;
          cnt_d     = in_popcnt;
          if (bus.in_vec == '0) begin
            zero_d = 1'b1;
          end else begin
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (out_fire) begin
          pending_d[hi_idx] = 1'b0;
          if (one_hot) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      zero_q    <= zero_d;
    end
  end

endmodule
